// File: rtl/lsu_mem_adapter.sv
// Purpose: load/store adapter between the mmu and data memory. It checks
//          alignment, builds byte enables, replicates store data across lanes
//          and extends load data. At most one memory transaction is in flight.
// Latency: with gnt in the first issue cycle and rvalid one cycle later, the
//          response comes 3 cycles after accept. A fault or misaligned request
//          responds 1 cycle after accept.
// Backpressure: req_ready_o is high only in IDLE. The bus fields hold until
//          mem_gnt_i. If TIMEOUT is nonzero, a stalled issue or wait ends in a fault.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   req_*                request from execute (valid/ready handshake)
//   mmu_*                translated address and access exception
//   mem_*                req/gnt/rvalid data-memory bus
//   rsp_*                one-cycle response pulse to retire
module lsu_mem_adapter #(
  parameter int TIMEOUT   = 256,
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] mmu_address_i,
  input  logic        mmu_exception_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_fault_o,
  output logic        rsp_misaligned_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The counter starts at 0 on entry. Firing on TIMEOUT-1 gives exactly
  // TIMEOUT cycles in the state. A gnt or rvalid in that last cycle still wins.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 we_q, uns_q, fault_q, mis_q;
  logic [1:0]           size_q;
  logic [31:0]          wdata_q, addr_q, rdata_q;
  logic [TIMEOUT_W-1:0] cnt_q;

  logic        accept, acc_fault, acc_mis, timeout_hit;
  logic        in_issue, in_resp;
  logic [3:0]  be;
  logic [31:0] wrep, shifted, ext;

  assign accept      = req_valid_i & req_ready_o;
  assign acc_fault   = mmu_exception_i | (req_size_i == 2'b11);
  assign acc_mis     = ((req_size_i == 2'b01) & mmu_address_i[0]) |
                       ((req_size_i == 2'b10) & (|mmu_address_i[1:0]));
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (acc_fault | acc_mis) ? RESP : ISSUE;
      ISSUE: if (mem_gnt_i) state_d = WAIT;
             else if (timeout_hit) state_d = RESP;
      // An rvalid in the gnt cycle arrives while still in ISSUE, so it is ignored.
      WAIT:  if (mem_rvalid_i | timeout_hit) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= req_we_i;
          uns_q   <= req_unsigned_i;
          size_q  <= req_size_i;
          wdata_q <= req_wdata_i;
          addr_q  <= mmu_address_i;
          rdata_q <= '0;
          fault_q <= acc_fault;
          mis_q   <= ~acc_fault & acc_mis;
          cnt_q   <= '0;
        end
        ISSUE: begin
          if (mem_gnt_i) cnt_q <= '0;
          else begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
            if (timeout_hit) fault_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + TIMEOUT_W'(1);
          if (mem_rvalid_i) rdata_q <= mem_rdata_i;
          else if (timeout_hit) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    be   = 4'b1111;
    wrep = wdata_q;
    case (size_q)
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << addr_q[1:0];
        wrep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from the access width.
  assign shifted = rdata_q >> {addr_q[1:0], 3'b000};
  always_comb begin
    ext = shifted;
    case (size_q)
      2'b00: ext = {{24{shifted[7]  & ~uns_q}}, shifted[7:0]};
      2'b01: ext = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
      default: ;
    endcase
  end

  assign in_issue         = (state_q == ISSUE);
  assign in_resp          = (state_q == RESP);
  assign req_ready_o      = (state_q == IDLE);
  assign mem_req_o        = in_issue;
  assign mem_addr_o       = in_issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_we_o         = in_issue & we_q;
  assign mem_be_o         = in_issue ? be : 4'b0000;
  assign mem_wdata_o      = in_issue ? wrep : 32'h0;
  assign rsp_valid_o      = in_resp;
  assign rsp_fault_o      = in_resp & fault_q;
  assign rsp_misaligned_o = in_resp & mis_q;
  assign rsp_data_o       = (in_resp & ~we_q & ~fault_q & ~mis_q) ? ext : 32'h0;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
module tb_lsu_mem_adapter;
  localparam int TO = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0, mmu_exception_i = 0;
  logic [1:0]  req_size_i = 0;
  logic [31:0] req_wdata_i = 0, mmu_address_i = 0;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic        req_ready_o, mem_req_o, mem_we_o, rsp_valid_o, rsp_fault_o, rsp_misaligned_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rsp_data_o;
  logic [3:0]  mem_be_o;

  lsu_mem_adapter #(.TIMEOUT(TO), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
    .mmu_address_i(mmu_address_i), .mmu_exception_i(mmu_exception_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_fault_o(rsp_fault_o), .rsp_misaligned_o(rsp_misaligned_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        mis;
    int          cyc;
  } rsp_t;

  // g: ISSUE cycles before gnt (>=TO means never); r: WAIT cycle of rvalid (0 means never)
  typedef struct {
    int          g;
    int          r;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          junk;
  } bus_t;

  rsp_t sq[$];
  bus_t bq[$];

  // Reference: byte lanes covered, store lane replication, extended load value.
  function automatic void model(input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                input logic [31:0] addr, input logic [31:0] rd,
                                output logic [3:0] be, output logic [31:0] wrep,
                                output logic [31:0] ld);
    int n = 1 << sz;
    int off = int'(addr[1:0]);
    be = 4'b0; wrep = 32'h0; ld = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) be[i] = 1'b1;
      wrep[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    for (int j = 0; j < n; j++) ld[8*j +: 8] = rd[8*(off + j) +: 8];
    if (n < 4 && !uns && ld[8*n - 1])
      for (int j = n; j < 4; j++) ld[8*j +: 8] = 8'hFF;
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input logic [31:0] addr, input logic exc,
                       input int g, input int r, input logic [31:0] rd, input bit junk);
    int w = 0;
    rsp_t e;
    bus_t b;
    logic flt, mis;
    @(negedge clk);
    while (!req_ready_o && w < 100) begin @(negedge clk); w++; end
    if (!req_ready_o) chk("ready_wait_expired", {31'b0, req_ready_o}, 32'h1);
    req_valid_i = 1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_wdata_i = wd; mmu_address_i = addr; mmu_exception_i = exc;
    flt = exc || (sz == 2'b11);
    mis = !flt && ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00));
    e.fault = flt; e.mis = mis; e.data = 32'h0;
    if (flt || mis) e.cyc = cyc + 1;
    else begin
      model(sz, uns, wd, addr, rd, b.be, b.wd, e.data);
      b.g = g; b.r = r; b.rdata = rd; b.addr = {addr[31:2], 2'b00}; b.we = we; b.junk = junk;
      bq.push_back(b);
      if (we) e.data = 32'h0;
      if (g >= TO) begin e.cyc = cyc + 1 + TO; e.fault = 1; e.data = 0; end
      else if (r == 0) begin e.cyc = cyc + 2 + g + TO; e.fault = 1; e.data = 0; end
      else e.cyc = cyc + 2 + g + r;
    end
    sq.push_back(e);
    @(posedge clk);
    #1 req_valid_i = 0;
  endtask

  // Memory responder: checks bus fields every issue cycle, then grants/responds.
  initial begin
    bus_t b;
    bit granted;
    forever begin
      @(negedge clk);
      if (mem_req_o && reset_n) begin
        if (bq.size() == 0) chk("bus_unexpected_req", {31'b0, mem_req_o}, 32'h0);
        else begin
          b = bq.pop_front();
          granted = 0;
          for (int k = 0; k < 40 && mem_req_o; k++) begin
            chk("bus_addr", mem_addr_o, b.addr);
            chk("bus_we", {31'b0, mem_we_o}, {31'b0, b.we});
            chk("bus_be", {28'b0, mem_be_o}, {28'b0, b.be});
            if (b.we) chk("bus_wdata", mem_wdata_o, b.wd);
            if (k == b.g) begin
              mem_gnt_i = 1; granted = 1;
              if (b.junk) begin mem_rvalid_i = 1; mem_rdata_i = $urandom; end
            end
            @(negedge clk);
            mem_gnt_i = 0; mem_rvalid_i = 0;
            if (granted) break;
          end
          if (granted && b.r > 0) begin
            for (int j = 1; j < b.r; j++) @(negedge clk);
            mem_rvalid_i = 1; mem_rdata_i = b.rdata;
            @(negedge clk);
            mem_rvalid_i = 0;
          end
        end
      end
    end
  end

  // Response monitor / scoreboard.
  rsp_t me;
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid_o) begin
        if (sq.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid_o}, 32'h0);
        else begin
          me = sq.pop_front();
          chk("rsp_data", rsp_data_o, me.data);
          chk("rsp_fault", {31'b0, rsp_fault_o}, {31'b0, me.fault});
          chk("rsp_misaligned", {31'b0, rsp_misaligned_o}, {31'b0, me.mis});
          chk("rsp_cycle", cyc, me.cyc);
        end
      end else begin
        chk("rsp_idle_zero", rsp_data_o | {30'b0, rsp_fault_o, rsp_misaligned_o}, 32'h0);
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int w;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, req_ready_o}, 32'h1);
    chk("reset_outputs", {27'b0, mem_req_o, mem_we_o, rsp_valid_o, rsp_fault_o, rsp_misaligned_o}, 32'h0);
    chk("reset_bus", mem_addr_o | mem_wdata_o | {28'b0, mem_be_o} | rsp_data_o, 32'h0);
    #2 reset_n = 1;

    issue(0, 2'b00, 0, 32'h0, 32'h1003, 0, 0, 1, 32'h80AABBCC, 0);
    issue(0, 2'b00, 1, 32'h0, 32'h1003, 0, 0, 1, 32'h80AABBCC, 1);
    issue(1, 2'b01, 0, 32'h1234, 32'h2002, 0, 3, 1, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h0, 32'h3001, 0, 0, 1, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h0, 32'h3000, 1, 0, 1, 32'h0, 0);
    issue(0, 2'b11, 0, 32'h0, 32'h3000, 0, 0, 1, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h0, 32'h4000, 0, 0, 0, 32'h0, 0);   // wait timeout
    issue(0, 2'b01, 0, 32'h0, 32'h4002, 0, 0, TO, 32'h8001_0000, 0);
    issue(1, 2'b10, 0, 32'hDEADBEEF, 32'h5000, 0, 99, 1, 32'h0, 0); // issue timeout
    issue(0, 2'b10, 0, 32'h0, 32'h0, 0, 0, 1, 32'hCAFEF00D, 0);
    issue(1, 2'b10, 0, 32'h01020304, 32'h4, 0, 0, 1, 32'h0, 0);

    // Reset while in WAIT: the response is dropped and the late rvalid is ignored.
    issue(0, 2'b10, 0, 32'h0, 32'h6000, 0, 0, 3, 32'h11111111, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("midreset_ready", {31'b0, req_ready_o}, 32'h1);
    chk("midreset_outputs", {29'b0, mem_req_o, rsp_valid_o, rsp_fault_o}, 32'h0);
    chk("midreset_be", {28'b0, mem_be_o}, 32'h0);
    void'(sq.pop_back());
    @(negedge clk);
    #3 reset_n = 1;
    repeat (4) @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, a,
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 19) == 0) ? 99 : $urandom_range(0, TO - 1),
            ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TO),
            $urandom, 1'($urandom_range(0, 1)));
    end

    w = 0;
    while ((sq.size() != 0 || bq.size() != 0) && w < 200) begin @(negedge clk); w++; end
    chk("drain_rsp_queue", sq.size(), 32'h0);
    chk("drain_bus_queue", bq.size(), 32'h0);
    @(negedge clk);
    chk("final_ready", {31'b0, req_ready_o}, 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
Load/store bus adapter directly downstream of the address-translation stage (mmu). It takes a load/store request from execute together with the translated address and exception flag from the mmu. It checks alignment, generates byte enables and replicated store data, and runs a single-outstanding req/gnt/rvalid transaction to data memory. It returns an aligned, sign- or zero-extended load result, or a fault/misaligned indication, to the retire stage.

Parameters:
TIMEOUT, 256, cycles allowed in ISSUE or WAIT before aborting with fault; 0 disables the timeout
TIMEOUT_W, 16, width of the timeout counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid from execute
req_ready_o  out  1  adapter can accept a request (state IDLE)
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned_i  in  1  zero-extend load result
req_wdata_i  in  32  store data, right-justified
mmu_address_i  in  32  translated address (mmu address_o)
mmu_exception_i  in  1  mmu access exception (mmu exception_o)
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_rvalid_i  in  1  response valid; required for loads and stores
mem_rdata_i  in  32  read data
rsp_valid_o  out  1  one-cycle response pulse
rsp_data_o  out  32  extended load data; 0 for stores and faults
rsp_fault_o  out  1  access fault (mmu exception, reserved size, timeout)
rsp_misaligned_o  out  1  misaligned address

Behaviour:
- Reset state: FSM in IDLE; req_ready_o=1; all other outputs 0; counter 0. Asserting reset mid-transaction aborts it with no response; a later stray mem_rvalid_i in IDLE is ignored.
- Handshake: request accepted when req_valid_i & req_ready_o. At acceptance, latch we, size, unsigned, wdata, address and address[1:0].
- Priority at acceptance:
  - mmu_exception_i or size=11 -> RESP with fault=1.
  - Else half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with misaligned=1.
  - Else -> ISSUE.
  - Faulted and misaligned requests never touch the bus, and never assert both flags.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- ISSUE: mem_req_o=1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are held stable until mem_gnt_i. On gnt -> WAIT.
- WAIT: on mem_rvalid_i -> RESP, capturing mem_rdata_i. An rvalid in the gnt cycle is not legal and is ignored.
- RESP: rsp_valid_o=1 for exactly one cycle, with rsp_data_o and the flags valid, then -> IDLE. Flags and data return to 0 outside RESP.
- Timeout: counter clears on entry to ISSUE and on entry to WAIT and increments each cycle in those states. When it reaches TIMEOUT (TIMEOUT>0): go to RESP with fault=1 and drop mem_req_o.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load data: shift rdata right by 8*addr[1:0], then sign-extend (zero-extend if unsigned) from bit 7 (byte) or bit 15 (half). Word loads pass through unchanged.
- Latency with gnt in the first ISSUE cycle and rvalid one cycle later: accept at T, mem_req_o at T+1, rvalid at T+2, rsp_valid_o at T+3, req_ready_o again at T+4. Fault/misaligned: rsp_valid_o at T+1.
- Only one transaction is outstanding; req_ready_o=0 in ISSUE, WAIT and RESP.

Test Plan:
- Load byte signed, addr 0x1003, rdata 0x80AABBCC -> mem_be_o 1000, mem_addr_o 0x1000, rsp_data_o 0xFFFFFF80; repeat with unsigned -> 0x00000080.
- Store half 0x1234 at 0x2002, gnt delayed 3 cycles -> mem_req_o and all bus fields stable for 4 cycles, be 1100, wdata 0x12341234, rsp_valid_o with data 0.
- Word load at 0x3001 -> rsp_valid_o at T+1 with misaligned=1, mem_req_o never asserted; mmu_exception_i=1 at aligned 0x3000 -> fault=1, misaligned=0, no bus activity.
- TIMEOUT=4, gnt given but rvalid withheld -> after 4 WAIT cycles rsp_valid_o with fault=1; FSM back in IDLE and accepting requests.
- Reset_n pulsed low while in WAIT -> outputs immediately at reset values, req_ready_o=1; late rvalid produces no rsp_valid_o.
- Back-to-back word load at 0x0 then store at 0x4, with gnt and rvalid immediate -> two responses spaced 4 cycles apart, correct be 1111.
